// File: rtl/isa_types_pkg.sv
// isa_types: shared memory-port types and constants for the hart
// Holds XLEN, the memory read latency, the memory control bundle and the
// in-flight read descriptor used by the memory port arbiter.
package isa_types;
  localparam int unsigned XLEN = 32;
  localparam int unsigned mem_read_latency = 2;
  typedef enum logic [1:0] {write_byte, write_half, write_word} mem_width_t;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic wenable;
    mem_width_t wwidth;
    logic [XLEN-1:0] wdata;
  } mem_control_t;
  typedef enum logic {OWNER_IF, OWNER_LS} mem_owner_t;
  typedef struct packed {
    logic valid;
    mem_owner_t owner;
  } mem_inflight_t;
  localparam mem_control_t MEM_CTL_IDLE = '{addr: '0, wenable: 1'b0, wwidth: write_word, wdata: '0};
  localparam mem_inflight_t INFLIGHT_NONE = '{valid: 1'b0, owner: OWNER_LS};
endpackage

// File: rtl/mem_port_arbiter_pipe.sv
// mem_latency_pipe: LATENCY-deep shift register of in-flight read descriptors
// Ports: clock, reset_n (sync active-low clear), push_i (descriptor entering
// stage 0 at each edge), tail_o (last stage, valid LATENCY cycles after push).
module mem_latency_pipe
  import isa_types::*;
#(
  parameter int unsigned LATENCY = mem_read_latency
) (
  input  logic          clock,
  input  logic          reset_n,
  input  mem_inflight_t push_i,
  output mem_inflight_t tail_o
);
  mem_inflight_t stage_q [LATENCY];
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < LATENCY; k++) stage_q[k] <= INFLIGHT_NONE;
    end else begin
      stage_q[0] <= push_i;
      for (int k = 1; k < LATENCY; k++) stage_q[k] <= stage_q[k-1];
    end
  end
  assign tail_o = stage_q[LATENCY-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store
// Ports: clock, reset_n (sync active-low); if_req/if_addr -> if_gnt, if_rsp_valid/if_rsp_data;
// ls_req/ls_ctl -> ls_gnt, ls_rsp_valid/ls_rsp_data; mem_ctl to memory, mem_q from memory.
// MEM_ARB_RR_EN: when defined, contention is resolved round-robin; otherwise LS always wins.
module mem_port_arbiter
  import isa_types::*;
#(
  parameter int unsigned LATENCY = mem_read_latency
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rsp_valid,
  output logic [XLEN-1:0] if_rsp_data,
  input  logic            ls_req,
  input  mem_control_t    ls_ctl,
  output logic            ls_gnt,
  output logic            ls_rsp_valid,
  output logic [XLEN-1:0] ls_rsp_data,
  output mem_control_t    mem_ctl,
  input  logic [XLEN-1:0] mem_q
);
  logic ls_win;
  mem_inflight_t push, tail;
`ifdef MEM_ARB_RR_EN
  // prio_q names the requester favoured on contention: the one not granted last.
  mem_owner_t prio_q, prio_d;
  assign ls_win = ls_req && (!if_req || prio_q == OWNER_LS);
  always_comb prio_d = ls_gnt ? OWNER_IF : if_gnt ? OWNER_LS : prio_q;
  always_ff @(posedge clock) begin
    if (!reset_n) prio_q <= OWNER_LS;
    else prio_q <= prio_d;
  end
`else
  assign ls_win = ls_req;
`endif
  // Grants are masked during reset so nothing is consumed while the pipe clears.
  assign ls_gnt = reset_n && ls_win;
  assign if_gnt = reset_n && if_req && !ls_win;
  always_comb begin
    mem_ctl = MEM_CTL_IDLE;
    push = INFLIGHT_NONE;
    if (ls_gnt) begin
      mem_ctl = ls_ctl;
      push = '{valid: !ls_ctl.wenable, owner: OWNER_LS};
    end else if (if_gnt) begin
      mem_ctl.addr = if_addr;
      push = '{valid: 1'b1, owner: OWNER_IF};
    end
  end
  mem_latency_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clock  (clock),
    .reset_n(reset_n),
    .push_i (push),
    .tail_o (tail)
  );
  assign if_rsp_valid = reset_n && tail.valid && tail.owner == OWNER_IF;
  assign ls_rsp_valid = reset_n && tail.valid && tail.owner == OWNER_LS;
  assign if_rsp_data = mem_q;
  assign ls_rsp_data = mem_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import isa_types::*;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n;
  logic if_req, if_gnt, if_rsp_valid, ls_req, ls_gnt, ls_rsp_valid;
  logic [XLEN-1:0] if_addr, if_rsp_data, ls_rsp_data, mem_q;
  mem_control_t ls_ctl, mem_ctl;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  mem_port_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_data (if_rsp_data),
    .ls_req      (ls_req),
    .ls_ctl      (ls_ctl),
    .ls_gnt      (ls_gnt),
    .ls_rsp_valid(ls_rsp_valid),
    .ls_rsp_data (ls_rsp_data),
    .mem_ctl     (mem_ctl),
    .mem_q       (mem_q)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    if_req = 1'b0;
    if_addr = '0;
    ls_req = 1'b0;
    ls_ctl = MEM_CTL_IDLE;
    mem_q = '0;
  endtask
  task automatic ls_set(input logic [31:0] a, input logic we, input logic [31:0] wd);
    ls_req = 1'b1;
    ls_ctl = '{addr: a, wenable: we, wwidth: write_word, wdata: wd};
  endtask
  initial begin
    reset_n = 1'b0;
    idle();
    if_req = 1'b1;
    if_addr = 32'h55;
    ls_set(32'h66, 1'b1, 32'h77);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_ls_gnt", 32'(ls_gnt), 0);
    chk("rst_addr", mem_ctl.addr, 0);
    chk("rst_we", 32'(mem_ctl.wenable), 0);
    chk("rst_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 0);
    reset_n = 1'b1;
    idle();
    cyc();
    // IF-only read
    if_req = 1'b1;
    if_addr = 32'h100;
    #1;
    chk("t1_if_gnt", 32'(if_gnt), 1);
    chk("t1_addr", mem_ctl.addr, 32'h100);
    chk("t1_we", 32'(mem_ctl.wenable), 0);
    chk("t1_wwidth", 32'(mem_ctl.wwidth), 32'(write_word));
    chk("t1_wdata", mem_ctl.wdata, 0);
    cyc();
    idle();
    #1;
    chk("t1_c1_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 0);
    chk("t1_c1_addr", mem_ctl.addr, 0);
    cyc();
    mem_q = 32'hDEADBEEF;
    #1;
    chk("t1_if_v", 32'(if_rsp_valid), 1);
    chk("t1_if_d", if_rsp_data, 32'hDEADBEEF);
    chk("t1_ls_v", 32'(ls_rsp_valid), 0);
    cyc();
    idle();
    // Both request at once: LS wins, IF follows
    if_req = 1'b1;
    if_addr = 32'h104;
    ls_set(32'h200, 1'b0, 0);
    #1;
    chk("t2_ls_gnt", 32'(ls_gnt), 1);
    chk("t2_if_gnt", 32'(if_gnt), 0);
    chk("t2_addr", mem_ctl.addr, 32'h200);
    cyc();
    ls_req = 1'b0;
    #1;
    chk("t2_c1_if_gnt", 32'(if_gnt), 1);
    chk("t2_c1_addr", mem_ctl.addr, 32'h104);
    cyc();
    idle();
    mem_q = 32'hA;
    #1;
    chk("t2_ls_v", 32'(ls_rsp_valid), 1);
    chk("t2_ls_d", ls_rsp_data, 32'hA);
    chk("t2_if_v0", 32'(if_rsp_valid), 0);
    cyc();
    mem_q = 32'hB;
    #1;
    chk("t2_if_v", 32'(if_rsp_valid), 1);
    chk("t2_if_d", if_rsp_data, 32'hB);
    chk("t2_ls_v0", 32'(ls_rsp_valid), 0);
    cyc();
    idle();
    // Alternating IF/LS/IF reads, memory returns addr+0x1000
    if_req = 1'b1;
    if_addr = 32'h0;
    #1;
    chk("t3_c0_if_gnt", 32'(if_gnt), 1);
    cyc();
    idle();
    ls_set(32'h4, 1'b0, 0);
    #1;
    chk("t3_c1_ls_gnt", 32'(ls_gnt), 1);
    chk("t3_c1_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 0);
    cyc();
    idle();
    if_req = 1'b1;
    if_addr = 32'h8;
    mem_q = 32'h1000;
    #1;
    chk("t3_c2_if_gnt", 32'(if_gnt), 1);
    chk("t3_c2_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 2);
    chk("t3_c2_d", if_rsp_data, 32'h1000);
    cyc();
    idle();
    mem_q = 32'h1004;
    #1;
    chk("t3_c3_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 1);
    chk("t3_c3_d", ls_rsp_data, 32'h1004);
    cyc();
    mem_q = 32'h1008;
    #1;
    chk("t3_c4_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 2);
    chk("t3_c4_d", if_rsp_data, 32'h1008);
    cyc();
    idle();
    #1;
    chk("t3_c5_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 0);
    // Store word: granted, drives the port, never responds
    ls_set(32'h300, 1'b1, 32'h12345678);
    #1;
    chk("t4_ls_gnt", 32'(ls_gnt), 1);
    chk("t4_we", 32'(mem_ctl.wenable), 1);
    chk("t4_wwidth", 32'(mem_ctl.wwidth), 32'(write_word));
    chk("t4_addr", mem_ctl.addr, 32'h300);
    chk("t4_wdata", mem_ctl.wdata, 32'h12345678);
    cyc();
    idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t4_norsp%0d", k), {30'd0, if_rsp_valid, ls_rsp_valid}, 0);
      cyc();
    end
    // Reset drops an in-flight read
    if_req = 1'b1;
    if_addr = 32'h400;
    #1;
    chk("t5_c0_if_gnt", 32'(if_gnt), 1);
    cyc();
    reset_n = 1'b0;
    ls_set(32'h500, 1'b1, 32'h9);
    #1;
    chk("t5_c1_gnt", {30'd0, if_gnt, ls_gnt}, 0);
    chk("t5_c1_we", 32'(mem_ctl.wenable), 0);
    chk("t5_c1_addr", mem_ctl.addr, 0);
    cyc();
    reset_n = 1'b1;
    idle();
    #1;
    chk("t5_c2_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 0);
    cyc();
    #1;
    chk("t5_c3_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 0);
    cyc();
    // Continuous contention for four cycles
    for (int k = 0; k < 4; k++) begin
      if_req = 1'b1;
      if_addr = 32'h600 + 32'(k);
      ls_set(32'h700 + 32'(k), 1'b0, 0);
      #1;
      chk($sformatf("t6_ls_gnt%0d", k), 32'(ls_gnt), RR ? 32'(k % 2 == 0) : 1);
      chk($sformatf("t6_if_gnt%0d", k), 32'(if_gnt), RR ? 32'(k % 2 == 1) : 0);
      cyc();
    end
    idle();
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
